wfq_event_issuer: RTL and testbench

//  Feeds the sum_weight block with WFQ arrival/depart events.

---
 rtl/wfq_event_issuer.sv | 215 +++++++++++++++++++++
 tb/tb_wfq_event_issuer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfq_event_issuer.sv
// WFQ event issuer: buffers enqueue/dequeue requests from the queue manager
// and turns them into single-cycle arrival/depart strobes for sum_weight.
// Each strobe is followed by a GAP-cycle idle window. A global backlog count
// is kept, and departs that would take it below zero are dropped.
module wfq_event_issuer #(
  parameter int FLOW_W  = 13,
  parameter int FIFO_AW = 2,
  parameter int GAP     = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arr_valid_i,
  output logic              arr_ready_o,
  input  logic [FLOW_W-1:0] arr_flow_i,
  input  logic              dep_valid_i,
  output logic              dep_ready_o,
  input  logic [FLOW_W-1:0] dep_flow_i,
  output logic              arrival_o,
  output logic              depart_o,
  output logic [FLOW_W-1:0] flow_id_o,
  output logic [CNT_W-1:0]  backlog_o,
  output logic              err_underflow_o,
  output logic              busy_o
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE  = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;
  localparam logic [3:0]         GAP_INIT = 4'(GAP);
  localparam logic [CNT_W-1:0]   BL_ONE   = 1;
  localparam logic [CNT_W-1:0]   BL_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  // Enqueue request FIFO
  logic [FLOW_W-1:0]  arrMem_q [DEPTH];
  logic [FIFO_AW-1:0] arrWr_q, arrRd_q;
  logic [FIFO_AW:0]   arrCnt_q;
  logic               arrPush, arrPop, arrEmpty, arrFull;

  // Dequeue request FIFO
  logic [FLOW_W-1:0]  depMem_q [DEPTH];
  logic [FIFO_AW-1:0] depWr_q, depRd_q;
  logic [FIFO_AW:0]   depCnt_q;
  logic               depPush, depPop, depEmpty, depFull;

  // Issue FSM state
  state_t             state_q, state_d;
  logic [3:0]         gapCnt_q, gapCnt_d;
  logic               arrival_q, arrival_d;
  logic               depart_q, depart_d;
  logic [FLOW_W-1:0]  flowId_q, flowId_d;
  logic [CNT_W-1:0]   backlog_q, backlog_d;
  logic               err_q, err_d;
  logic               lastArr_q, lastArr_d;
  logic               selOk, pickArr, pickDep;

  assign arrFull     = (arrCnt_q == FULL_CNT);
  assign arrEmpty    = (arrCnt_q == '0);
  assign arr_ready_o = !arrFull;
  assign arrPush     = arr_valid_i && !arrFull;

  assign depFull     = (depCnt_q == FULL_CNT);
  assign depEmpty    = (depCnt_q == '0);
  assign dep_ready_o = !depFull;
  assign depPush     = dep_valid_i && !depFull;

  // Enqueue FIFO storage and pointers; push and pop may coincide
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arrWr_q  <= '0;
      arrRd_q  <= '0;
      arrCnt_q <= '0;
    end else begin
      if (arrPush) begin
        arrMem_q[arrWr_q] <= arr_flow_i;
        arrWr_q           <= arrWr_q + PTR_ONE;
      end
      if (arrPop) begin
        arrRd_q <= arrRd_q + PTR_ONE;
      end
      if (arrPush && !arrPop) begin
        arrCnt_q <= arrCnt_q + CNT_ONE;
      end else if (!arrPush && arrPop) begin
        arrCnt_q <= arrCnt_q - CNT_ONE;
      end
    end
  end

  // Dequeue FIFO storage and pointers; push and pop may coincide
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      depWr_q  <= '0;
      depRd_q  <= '0;
      depCnt_q <= '0;
    end else begin
      if (depPush) begin
        depMem_q[depWr_q] <= dep_flow_i;
        depWr_q           <= depWr_q + PTR_ONE;
      end
      if (depPop) begin
        depRd_q <= depRd_q + PTR_ONE;
      end
      if (depPush && !depPop) begin
        depCnt_q <= depCnt_q + CNT_ONE;
      end else if (!depPush && depPop) begin
        depCnt_q <= depCnt_q - CNT_ONE;
      end
    end
  end

  // Next-state logic: the last gap cycle selects like IDLE, so strobes can be GAP+1 apart
  always_comb begin
    state_d   = state_q;
    gapCnt_d  = gapCnt_q;
    arrival_d = 1'b0;
    depart_d  = 1'b0;
    flowId_d  = '0;
    backlog_d = backlog_q;
    err_d     = 1'b0;
    lastArr_d = lastArr_q;
    arrPop    = 1'b0;
    depPop    = 1'b0;
    selOk     = 1'b0;
    pickArr   = 1'b0;
    pickDep   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        selOk = 1'b1;
      end
      S_ISSUE: begin
        state_d  = S_GAP;
        gapCnt_d = GAP_INIT;
        if (arrival_q) begin
          if (backlog_q != BL_MAX) begin
            backlog_d = backlog_q + BL_ONE;
          end
        end else if (depart_q) begin
          backlog_d = backlog_q - BL_ONE;
        end
      end
      S_GAP: begin
        if (gapCnt_q <= 4'd1) begin
          state_d = S_IDLE;
          selOk   = 1'b1;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (selOk) begin
      pickArr = !arrEmpty && (depEmpty || !lastArr_q);
      pickDep = !depEmpty && !pickArr;
      if (pickArr) begin
        arrPop    = 1'b1;
        arrival_d = 1'b1;
        flowId_d  = arrMem_q[arrRd_q];
        lastArr_d = 1'b1;
        state_d   = S_ISSUE;
      end else if (pickDep) begin
        depPop    = 1'b1;
        lastArr_d = 1'b0;
        if (backlog_q == '0) begin
          err_d = 1'b1;
        end else begin
          depart_d = 1'b1;
          flowId_d = depMem_q[depRd_q];
          state_d  = S_ISSUE;
        end
      end
    end
  end

  // FSM and output registers; the arbiter starts as if a depart was last served
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      gapCnt_q  <= '0;
      arrival_q <= 1'b0;
      depart_q  <= 1'b0;
      flowId_q  <= '0;
      backlog_q <= '0;
      err_q     <= 1'b0;
      lastArr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gapCnt_q  <= gapCnt_d;
      arrival_q <= arrival_d;
      depart_q  <= depart_d;
      flowId_q  <= flowId_d;
      backlog_q <= backlog_d;
      err_q     <= err_d;
      lastArr_q <= lastArr_d;
    end
  end

  assign arrival_o       = arrival_q;
  assign depart_o        = depart_q;
  assign flow_id_o       = flowId_q;
  assign backlog_o       = backlog_q;
  assign err_underflow_o = err_q;
  assign busy_o          = (state_q != S_IDLE) || !arrEmpty || !depEmpty;

endmodule

// File: tb/tb_wfq_event_issuer.sv
// Testbench for wfq_event_issuer: a scoreboard of expected strobes (type,
// flow, backlog afterwards, spacing) filled by each scenario task and drained
// by a monitor that watches the strobe outputs.
module tb_wfq_event_issuer;

  localparam int FLOW_W = 13;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              arrValid, depValid;
  logic [FLOW_W-1:0] arrFlow, depFlow;
  logic              arrReady, depReady;
  logic              arrival, depart;
  logic [FLOW_W-1:0] flowId;
  logic [CNT_W-1:0]  backlog;
  logic              errUnderflow, busy;

  typedef struct {
    bit                is_arr;
    logic [FLOW_W-1:0] flow;
    logic [CNT_W-1:0]  bl;
    int                gap;
  } exp_t;

  exp_t              sb[$];
  logic [FLOW_W-1:0] arrSrc[$];
  logic [FLOW_W-1:0] depSrc[$];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lastStrobeCyc = 0;
  int   firstStrobeCyc = -1;
  int   firstPushCyc = -1;
  int   errCycles = 0;
  int   strobeCount = 0;
  bit   arrReadyLowSeen = 0;
  bit   blPending = 0;
  logic [CNT_W-1:0] blExp;

  wfq_event_issuer dut (
    .clk_i(clk),
    .rst_i(rst),
    .arr_valid_i(arrValid),
    .arr_ready_o(arrReady),
    .arr_flow_i(arrFlow),
    .dep_valid_i(depValid),
    .dep_ready_o(depReady),
    .dep_flow_i(depFlow),
    .arrival_o(arrival),
    .depart_o(depart),
    .flow_id_o(flowId),
    .backlog_o(backlog),
    .err_underflow_o(errUnderflow),
    .busy_o(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Edge counter used for latency and spacing measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops one expectation per strobe, checks backlog a cycle later
  always @(negedge clk) begin
    if (rst) begin
      blPending = 0;
    end else begin
      if (blPending) begin
        checks++;
        if (backlog !== blExp) begin
          failures++;
          $display("[TB] FAIL backlog_after_strobe: got %0d expected %0d", backlog, blExp);
        end
        blPending = 0;
      end
      checks++;
      if (arrival && depart) begin
        failures++;
        $display("[TB] FAIL strobe_exclusive: got arrival=%0b depart=%0b expected one at most", arrival, depart);
      end
      if (!arrival && !depart) begin
        checks++;
        if (flowId !== '0) begin
          failures++;
          $display("[TB] FAIL flow_id_idle: got %0d expected 0", flowId);
        end
      end else begin
        exp_t e;
        strobeCount++;
        if (firstStrobeCyc < 0) firstStrobeCyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_strobe: got arrival=%0b depart=%0b flow=%0d expected none", arrival, depart, flowId);
        end else begin
          e = sb.pop_front();
          if (arrival !== e.is_arr) begin
            failures++;
            $display("[TB] FAIL strobe_type: got arrival=%0b expected arrival=%0b", arrival, e.is_arr);
          end
          checks++;
          if (flowId !== e.flow) begin
            failures++;
            $display("[TB] FAIL strobe_flow: got %0d expected %0d", flowId, e.flow);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - lastStrobeCyc != e.gap) begin
              failures++;
              $display("[TB] FAIL strobe_spacing: got %0d expected %0d", cyc - lastStrobeCyc, e.gap);
            end
          end
          blPending = 1;
          blExp = e.bl;
        end
        lastStrobeCyc = cyc;
      end
      if (errUnderflow) errCycles++;
    end
  end

  function automatic void pushExp(bit isArr, int flow, int bl, int gap);
    exp_t e;
    e.is_arr = isArr;
    e.flow   = FLOW_W'(flow);
    e.bl     = CNT_W'(bl);
    e.gap    = gap;
    sb.push_back(e);
  endfunction

  // Drives arrSrc/depSrc through valid/ready, departs starting depDelay cycles in
  task automatic applyStimulus(input int depDelay);
    int  i;
    bit  aV, dV, aR, dR;
    i = 0;
    while ((arrSrc.size() > 0 || depSrc.size() > 0) && i < 200) begin
      aV = (arrSrc.size() > 0);
      dV = (i >= depDelay) && (depSrc.size() > 0);
      arrValid = aV;
      arrFlow  = aV ? arrSrc[0] : '0;
      depValid = dV;
      depFlow  = dV ? depSrc[0] : '0;
      aR = arrReady;
      dR = depReady;
      if (aV && !aR) arrReadyLowSeen = 1;
      @(posedge clk);
      #1;
      if (aV && aR) begin
        void'(arrSrc.pop_front());
        if (firstPushCyc < 0) firstPushCyc = cyc;
      end
      if (dV && dR) void'(depSrc.pop_front());
      @(negedge clk);
      #1;
      i++;
    end
    arrValid = 1'b0;
    depValid = 1'b0;
    arrFlow  = '0;
    depFlow  = '0;
    checks++;
    if (arrSrc.size() != 0 || depSrc.size() != 0) begin
      failures++;
      $display("[TB] FAIL push_timeout: got %0d requests left expected 0", arrSrc.size() + depSrc.size());
      arrSrc.delete();
      depSrc.delete();
    end
  endtask

  // Waits for every expected strobe and for the DUT to go idle
  task automatic checkOutput();
    int n;
    n = 0;
    while ((sb.size() > 0 || busy) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending busy=%0b expected 0 pending busy=0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (arrival !== 1'b0 || depart !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %0b%0b expected 00", arrival, depart);
    end
    checks++;
    if (flowId !== '0 || backlog !== '0) begin
      failures++;
      $display("[TB] FAIL reset_flow_backlog: got %0d/%0d expected 0/0", flowId, backlog);
    end
    checks++;
    if (errUnderflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err_busy: got %0b/%0b expected 0/0", errUnderflow, busy);
    end
    checks++;
    if (arrReady !== 1'b1 || depReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %0b/%0b expected 1/1", arrReady, depReady);
    end
  endtask

  task automatic test_arrivals();
    pushExp(1, 1, 1, 0);
    pushExp(1, 1, 2, 2);
    pushExp(1, 1, 3, 2);
    arrSrc = '{13'd1, 13'd1, 13'd1};
    firstStrobeCyc = -1;
    firstPushCyc = -1;
    applyStimulus(0);
    checkOutput();
    checks++;
    if (firstStrobeCyc - firstPushCyc != 1) begin
      failures++;
      $display("[TB] FAIL first_latency: got %0d expected 1", firstStrobeCyc - firstPushCyc);
    end
    checks++;
    if (backlog !== 16'd3) begin
      failures++;
      $display("[TB] FAIL arrivals_backlog: got %0d expected 3", backlog);
    end
  endtask

  task automatic test_departs();
    int err0;
    err0 = errCycles;
    pushExp(0, 1, 2, 0);
    pushExp(0, 1, 1, 2);
    pushExp(0, 1, 0, 2);
    depSrc = '{13'd1, 13'd1, 13'd1};
    applyStimulus(0);
    checkOutput();
    checks++;
    if (errCycles != err0) begin
      failures++;
      $display("[TB] FAIL departs_no_err: got %0d err cycles expected 0", errCycles - err0);
    end
    checks++;
    if (backlog !== 16'd0) begin
      failures++;
      $display("[TB] FAIL departs_backlog: got %0d expected 0", backlog);
    end
  endtask

  task automatic test_underflow();
    int err0, str0;
    err0 = errCycles;
    str0 = strobeCount;
    depSrc = '{13'd4};
    applyStimulus(0);
    checkOutput();
    checks++;
    if (errCycles - err0 != 1) begin
      failures++;
      $display("[TB] FAIL underflow_pulse: got %0d err cycles expected 1", errCycles - err0);
    end
    checks++;
    if (strobeCount != str0) begin
      failures++;
      $display("[TB] FAIL underflow_no_strobe: got %0d strobes expected 0", strobeCount - str0);
    end
    checks++;
    if (backlog !== 16'd0) begin
      failures++;
      $display("[TB] FAIL underflow_backlog: got %0d expected 0", backlog);
    end
  endtask

  task automatic test_mixed();
    pushExp(1, 5, 1, 0);
    pushExp(1, 2, 2, 2);
    pushExp(0, 5, 1, 2);
    pushExp(1, 3, 2, 2);
    pushExp(0, 2, 1, 2);
    arrSrc = '{13'd5, 13'd2, 13'd3};
    depSrc = '{13'd5, 13'd2};
    applyStimulus(3);
    checkOutput();
    checks++;
    if (backlog !== 16'd1) begin
      failures++;
      $display("[TB] FAIL mixed_backlog: got %0d expected 1", backlog);
    end
  endtask

  task automatic test_back_to_back();
    pushExp(1, 10, 2, 0);
    pushExp(0, 20, 1, 2);
    pushExp(1, 11, 2, 2);
    pushExp(0, 21, 1, 2);
    pushExp(1, 12, 2, 2);
    pushExp(1, 13, 3, 2);
    pushExp(1, 14, 4, 2);
    pushExp(1, 15, 5, 2);
    arrSrc = '{13'd10, 13'd11, 13'd12, 13'd13, 13'd14, 13'd15};
    depSrc = '{13'd20, 13'd21};
    arrReadyLowSeen = 0;
    applyStimulus(0);
    checkOutput();
    checks++;
    if (arrReadyLowSeen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_backpressure: got %0b expected 1", arrReadyLowSeen);
    end
    checks++;
    if (backlog !== 16'd5) begin
      failures++;
      $display("[TB] FAIL b2b_backlog: got %0d expected 5", backlog);
    end
  endtask

  task automatic test_reset_mid_strobe();
    int str0;
    pushExp(1, 7, 6, 0);
    arrValid = 1'b1;
    arrFlow  = 13'd7;
    @(posedge clk);
    @(negedge clk);
    #1;
    arrFlow = 13'd8;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (arrival !== 1'b1 || flowId !== 13'd7) begin
      failures++;
      $display("[TB] FAIL pre_reset_strobe: got arrival=%0b flow=%0d expected 1/7", arrival, flowId);
    end
    rst = 1'b1;
    arrValid = 1'b0;
    arrFlow  = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (arrival !== 1'b0 || depart !== 1'b0 || flowId !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_strobe: got %0b%0b flow=%0d expected 00 flow=0", arrival, depart, flowId);
    end
    checks++;
    if (backlog !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_backlog: got %0d expected 0", backlog);
    end
    checks++;
    if (busy !== 1'b0 || arrReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_reset_fifo: got busy=%0b ready=%0b expected 0/1", busy, arrReady);
    end
    rst = 1'b0;
    sb.delete();
    str0 = strobeCount;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (strobeCount != str0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_quiet: got %0d strobes busy=%0b expected 0/0", strobeCount - str0, busy);
    end
  endtask

  // Scenario sequence
  initial begin
    rst      = 1'b1;
    arrValid = 1'b0;
    depValid = 1'b0;
    arrFlow  = '0;
    depFlow  = '0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] arrivals");
    test_arrivals();
    $display("[TB] departs");
    test_departs();
    $display("[TB] underflow");
    test_underflow();
    $display("[TB] mixed arbitration");
    test_mixed();
    $display("[TB] back to back");
    test_back_to_back();
    $display("[TB] reset mid strobe");
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
